conv_frame_sequencer: RTL

CONV_FRAME_SEQUENCER -- requirements
Module: conv_frame_sequencer

---
 rtl/conv_seq_pkg.sv | 17 +
 rtl/conv_seq_fifo.sv | 52 +++++
 rtl/conv_frame_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and default geometry for the convolution frame sequencer.
package conv_seq_pkg;

    localparam int unsigned IMG_W_DEF      = 28;
    localparam int unsigned IMG_H_DEF      = 28;
    localparam int unsigned PP_DEF         = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // Frame-level sequencing states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2,
        StDone   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/conv_seq_fifo.sv
// Result buffer: synchronous FIFO with flush. A pop and a push in the same cycle
// always succeed, even when full, because the pop frees the slot first.
module conv_seq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_pop_eff;
    logic             w_push_eff;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign o_empty    = (w_count == '0);
    assign o_full     = (w_count == (AW + 1)'(DEPTH));
    assign w_pop_eff  = i_pop && !o_empty;
    assign w_push_eff = i_push && (!o_full || w_pop_eff);
    assign o_head     = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any push/pop in the same cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_eff) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
            if (w_pop_eff)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage write; contents are never visible while empty, so no reset is needed
    always_ff @(posedge i_clk) begin
        if (w_push_eff && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer between an SPI slave and a stack of conv layers: streams
// pixel bytes into the layers, buffers the summed results for MISO, and tracks
// frame boundaries. Define CONV_SEQ_SATURATE_EN to clamp results to 0..2^PP-1
// instead of truncating them.
module conv_frame_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned IMG_W      = IMG_W_DEF,
    parameter int unsigned IMG_H      = IMG_H_DEF,
    parameter int unsigned PP         = PP_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ssel_active,
    input  logic [7:0]    rx_byte,
    input  logic          rx_valid,
    input  logic          tx_ready,
    input  logic [8:0]    res_in,
    input  logic          res_valid,
    output logic [8:0]    pxl_out,
    output logic          pxl_strobe,
    output logic          layer_reset,
    output logic [PP-1:0] tx_byte,
    output logic          frame_done,
    output logic          overflow
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    seq_state_e r_state;
    seq_state_e w_state_next;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [8:0]       r_pxl_out;
    logic             r_pxl_strobe;
    logic             r_layer_reset;
    logic             r_frame_done;
    logic             r_overflow;
    logic             r_quiet;

    logic          w_start;
    logic          w_abort;
    logic          w_enter_done;
    logic          w_last_pix;
    logic          w_accept;
    logic          w_drain_quiet;
    logic          w_push;
    logic          w_drop;
    logic [PP-1:0] w_res_conv;
    logic [PP-1:0] w_fifo_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;

    // Abort is level-based: ssel can only be low here after having risen in IDLE
    assign w_abort       = ((r_state == StStream) || (r_state == StDrain)) && !ssel_active;
    assign w_last_pix    = r_pxl_strobe && (r_col == COL_LAST) && (r_row == ROW_LAST);
    // No new pixel is taken in the cycle that strobes the final one
    assign w_accept      = (r_state == StStream) && ssel_active && rx_valid && !w_last_pix;
    assign w_drain_quiet = w_fifo_empty && !res_valid;
    assign w_push        = res_valid && !w_abort;
    // Full with a pop pending is not an overflow: the pop frees the slot first
    assign w_drop        = w_push && w_fifo_full && !tx_ready;

`ifdef CONV_SEQ_SATURATE_EN
    localparam logic signed [PP+8:0] RES_MAX = {9'd0, {PP{1'b1}}};
    logic signed [PP+8:0] w_res_ext;

    assign w_res_ext = {{PP{res_in[8]}}, res_in};

    // Clamp the signed layer sum into the unsigned result byte range
    always_comb begin
        w_res_conv = w_res_ext[PP-1:0];
        if (w_res_ext[PP+8]) begin
            w_res_conv = '0;
        end else if (w_res_ext > RES_MAX) begin
            w_res_conv = '1;
        end
    end
`else
    assign w_res_conv = res_in[PP-1:0];
`endif

    // Next-state decode for the frame FSM
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_enter_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (ssel_active) begin
                    w_state_next = StStream;
                    w_start      = 1'b1;
                end
            end
            StStream: begin
                if (!ssel_active)   w_state_next = StIdle;
                else if (w_last_pix) w_state_next = StDrain;
            end
            StDrain: begin
                if (!ssel_active) begin
                    w_state_next = StIdle;
                end else if (w_drain_quiet && r_quiet) begin
                    w_state_next = StDone;
                    w_enter_done = 1'b1;
                end
            end
            StDone: begin
                if (!ssel_active) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM state and one-cycle control pulses
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= StIdle;
            r_layer_reset <= 1'b0;
            r_frame_done  <= 1'b0;
            r_quiet       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_layer_reset <= w_start || w_abort;
            r_frame_done  <= w_enter_done;
            // Remembers that the previous DRAIN cycle was already quiet
            r_quiet       <= (r_state == StDrain) && w_drain_quiet;
        end
    end

    // Pixel latch and strobe, one cycle after each accepted rx byte
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pxl_out    <= '0;
            r_pxl_strobe <= 1'b0;
        end else begin
            r_pxl_strobe <= w_accept;
            if (w_accept) r_pxl_out <= {1'b0, rx_byte};
        end
    end

    // Column/row position of the next pixel, advanced by each strobe
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_start || w_abort) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_pxl_strobe) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Sticky overflow, cleared only when a new frame starts
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    conv_seq_fifo #(
        .WIDTH (PP),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_pop   (tx_ready),
        .i_data  (w_res_conv),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign pxl_out     = r_pxl_out;
    assign pxl_strobe  = r_pxl_strobe;
    assign layer_reset = r_layer_reset;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign tx_byte     = w_fifo_empty ? '0 : w_fifo_head;

endmodule
